game_state_ctrl: RTL and testbench

//  Top-level screen sequencer for SkyHop. Drives the module_en lines of the start, game and end

---
 rtl/game_state_ctrl_pkg.sv | 47 ++++
 rtl/game_state_ctrl_edge_pulse.sv | 24 ++
 rtl/game_state_ctrl.sv | 171 +++++++++++++++++
 tb/tb_game_state_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_state_ctrl_pkg.sv
// Shared state encodings and overlay-enable decode for the SkyHop
// screen sequencer. The optional pause feature is enabled by GAME_PAUSE_EN.
package game_state_ctrl_pkg;

    localparam int GST_W = 3;
    localparam int CNT_W = 10;

    typedef enum logic [GST_W-1:0] {
        GST_START = 3'd0,
        GST_PLAY  = 3'd1,
        GST_DYING = 3'd2,
        GST_END   = 3'd3,
        GST_PAUSE = 3'd4
    } gst_e;

    typedef struct packed {
        logic start_en;
        logic game_en;
        logic end_en;
        logic freeze;
    } ovl_t;

    function automatic ovl_t ovl_decode(input gst_e s);
        ovl_t o;
        o = '0;
        case (s)
            GST_START: o.start_en = 1'b1;
            GST_PLAY:  o.game_en  = 1'b1;
            GST_DYING: begin
                o.game_en = 1'b1;
                o.freeze  = 1'b1;
            end
            GST_END: begin
                o.game_en = 1'b1;
                o.freeze  = 1'b1;
                o.end_en  = 1'b1;
            end
            GST_PAUSE: begin
                o.game_en = 1'b1;
                o.freeze  = 1'b1;
            end
            default:   o.start_en = 1'b1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/game_state_ctrl_edge_pulse.sv
// edge_pulse: registered rising-edge detector, one-cycle pulse out.
// Ports: clk, rst_n, d (level in), pulse (1 cycle after a 0->1 on d).
module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic prev;

    // prev resets high so a level already high when reset releases
    // is not seen as a new edge; a real 0 must be observed first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= 1'b1;
            pulse <= 1'b0;
        end else begin
            prev  <= d;
            pulse <= d & ~prev;
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// SkyHop screen sequencer: frame-aligned START/PLAY/DYING/END FSM driving
// overlay enables and a game_rst pulse. Ports: clk, rst_n, vsync_in,
// btn_start, collision, fell_off (+btn_pause with GAME_PAUSE_EN) in;
// start_en, game_en, end_en, freeze, game_rst, state_out[2:0] out.
module game_state_ctrl
    import game_state_ctrl_pkg::*;
#(
    parameter int DYING_FRAMES    = 30,
    parameter int END_HOLD_FRAMES = 120,
    parameter int AUTO_RET_FRAMES = 900
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync_in,
    input  logic             btn_start,
`ifdef GAME_PAUSE_EN
    input  logic             btn_pause,
`endif
    input  logic             collision,
    input  logic             fell_off,
    output logic             start_en,
    output logic             game_en,
    output logic             end_en,
    output logic             freeze,
    output logic             game_rst,
    output logic [GST_W-1:0] state_out
);

    localparam logic [CNT_W-1:0] DY_LAST  = CNT_W'(DYING_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_MIN = CNT_W'(END_HOLD_FRAMES);
    localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_RET_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic tick;
    logic start_p;
    gst_e state;
    gst_e nxt;
    logic [CNT_W-1:0] cnt;
    logic start_req;
    logic sreq;
    logic go_rst;
    logic drop_start;
    logic keep_cnt;
    logic cnt_run;
    ovl_t ovl;
    ovl_t ovl_nxt;

    edge_pulse u_vs (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (vsync_in),
        .pulse (tick)
    );

    edge_pulse u_start (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_start),
        .pulse (start_p)
    );

`ifdef GAME_PAUSE_EN
    logic pause_p;
    logic pause_req;
    logic preq;

    edge_pulse u_pause (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_pause),
        .pulse (pause_p)
    );

    assign preq = pause_req | pause_p;
`endif

    // A press landing on the tick cycle itself still counts.
    assign sreq = start_req | start_p;

    always_comb begin
        nxt        = state;
        go_rst     = 1'b0;
        drop_start = 1'b0;
        keep_cnt   = 1'b0;
        cnt_run    = 1'b1;
        case (state)
            GST_START: begin
                if (tick && sreq) begin
                    nxt    = GST_PLAY;
                    go_rst = 1'b1;
                end
            end
            GST_PLAY: begin
                if (tick && (collision | fell_off)) begin
                    nxt = GST_DYING;
`ifdef GAME_PAUSE_EN
                end else if (tick && preq) begin
                    nxt      = GST_PAUSE;
                    keep_cnt = 1'b1;
`endif
                end
            end
            GST_DYING: begin
                if (tick && cnt == DY_LAST)
                    nxt = GST_END;
            end
            GST_END: begin
                if (tick && sreq && cnt >= HOLD_MIN) begin
                    nxt    = GST_PLAY;
                    go_rst = 1'b1;
                end else if (tick) begin
                    // Presses inside the hold window are thrown away.
                    drop_start = sreq;
                    if (cnt == AUTO_LAST)
                        nxt = GST_START;
                end
            end
`ifdef GAME_PAUSE_EN
            GST_PAUSE: begin
                cnt_run = 1'b0;
                if (tick && preq) begin
                    nxt      = GST_PLAY;
                    keep_cnt = 1'b1;
                end
            end
`endif
            default: nxt = GST_START;
        endcase
    end

    assign ovl_nxt = ovl_decode(nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= GST_START;
            cnt       <= '0;
            start_req <= 1'b0;
            ovl       <= ovl_decode(GST_START);
            game_rst  <= 1'b0;
`ifdef GAME_PAUSE_EN
            pause_req <= 1'b0;
`endif
        end else begin
            state    <= nxt;
            ovl      <= ovl_nxt;
            game_rst <= go_rst;
            if (nxt != state) begin
                start_req <= 1'b0;
`ifdef GAME_PAUSE_EN
                pause_req <= 1'b0;
`endif
                if (!keep_cnt)
                    cnt <= '0;
            end else begin
                start_req <= drop_start ? 1'b0 : sreq;
`ifdef GAME_PAUSE_EN
                pause_req <= preq;
`endif
                if (tick && cnt_run && cnt != CNT_MAX)
                    cnt <= cnt + 1'b1;
            end
        end
    end

    assign start_en  = ovl.start_en;
    assign game_en   = ovl.game_en;
    assign end_en    = ovl.end_en;
    assign freeze    = ovl.freeze;
    assign state_out = state;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: every output change is popped
// against a queue of predicted {outputs, frame index} entries.
module tb_game_state_ctrl;

    logic       clk;
    logic       rst_n;
    logic       vsync_in;
    logic       btn_start;
    logic       btn_pause;
    logic       collision;
    logic       fell_off;
    logic       start_en;
    logic       game_en;
    logic       end_en;
    logic       freeze;
    logic       game_rst;
    logic [2:0] state_out;

    game_state_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vsync_in  (vsync_in),
        .btn_start (btn_start),
`ifdef GAME_PAUSE_EN
        .btn_pause (btn_pause),
`endif
        .collision (collision),
        .fell_off  (fell_off),
        .start_en  (start_en),
        .game_en   (game_en),
        .end_en    (end_en),
        .freeze    (freeze),
        .game_rst  (game_rst),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] v;
        int         t;
        string      name;
    } exp_t;

    exp_t       sb[$];
    int         tk;
    int         nchk;
    int         npass;
    logic [7:0] outv;

    assign outv = {state_out, start_en, game_en,
                   end_en, freeze, game_rst};

    // Expected output vector for a state (independent decode table).
    function automatic logic [7:0] ev(input int s, input logic r);
        logic [4:0] f;
        case (s)
            0:       f = 5'b1000_0;
            1:       f = 5'b0100_0;
            2:       f = 5'b0101_0;
            3:       f = 5'b0111_0;
            default: f = 5'b0101_0;
        endcase
        f[0] = r;
        return {3'(s), f};
    endfunction

    task automatic expect_st(input string n, input int s,
                             input logic r, input int t);
        exp_t e;
        e.v = ev(s, r);
        e.t = t;
        e.name = n;
        sb.push_back(e);
    endtask

    // Next PLAY entry: game_rst rises then falls on the same frame.
    task automatic expect_play(input string n, input int t);
        expect_st({n, "_rst"}, 1, 1'b1, t);
        expect_st({n, "_play"}, 1, 1'b0, t);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vsync_in = 1'b1;
            tk++;
            repeat (3) @(negedge clk);
            vsync_in = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic press_start();
        @(negedge clk);
        btn_start = 1'b1;
        repeat (2) @(negedge clk);
        btn_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_pause();
        @(negedge clk);
        btn_pause = 1'b1;
        repeat (2) @(negedge clk);
        btn_pause = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: each output change is a transaction to score.
    initial begin
        exp_t e;
        forever begin
            @(outv);
            #1;
            nchk++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_change got=%b tick=%0d",
                         outv, tk);
            end else begin
                e = sb.pop_front();
                if (outv === e.v && tk == e.t)
                    npass++;
                else
                    $display("FAIL %s got=%b@%0d want=%b@%0d",
                             e.name, outv, tk, e.v, e.t);
            end
        end
    end

    initial begin
        exp_t e;
        tk = 0;
        nchk = 0;
        npass = 0;
        vsync_in = 1'b0;
        btn_start = 1'b1;
        btn_pause = 1'b0;
        collision = 1'b0;
        fell_off = 1'b0;
        rst_n = 1'b1;

        // Reset with btn_start already held high.
        expect_st("reset", 0, 1'b0, 0);
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        frames(2);
        btn_start = 1'b0;
        frames(1);

        // Start press mid-frame -> PLAY on next tick.
        press_start();
        expect_play("t1", tk + 1);
        frames(1);

        // Short collision between ticks is ignored.
        @(negedge clk);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        frames(2);

        // Held collision -> DYING, then END after 30 ticks.
        collision = 1'b1;
        expect_st("t2_dying", 2, 1'b0, tk + 1);
        frames(1);
        collision = 1'b0;
        expect_st("t2_end", 3, 1'b0, tk + 30);
        frames(30);

        // Hold window: press at frame 50 discarded.
        frames(50);
        press_start();
        frames(1);
        frames(79);
        press_start();
        expect_play("t3", tk + 1);
        frames(1);

        // Auto-return to START after 900 ticks in END.
        fell_off = 1'b1;
        expect_st("t4_dying", 2, 1'b0, tk + 1);
        frames(1);
        fell_off = 1'b0;
        expect_st("t4_end", 3, 1'b0, tk + 30);
        frames(30);
        expect_st("t4_auto", 0, 1'b0, tk + 900);
        frames(900);

        // Start on the auto-return tick wins.
        press_start();
        expect_play("t4b", tk + 1);
        frames(1);
        collision = 1'b1;
        expect_st("t4b_dying", 2, 1'b0, tk + 1);
        frames(1);
        collision = 1'b0;
        expect_st("t4b_end", 3, 1'b0, tk + 30);
        frames(30);
        frames(899);
        press_start();
        expect_play("t4c", tk + 1);
        frames(1);

        // Async reset mid-DYING, btn_start held through it.
        collision = 1'b1;
        expect_st("t5_dying", 2, 1'b0, tk + 1);
        frames(1);
        collision = 1'b0;
        frames(5);
        btn_start = 1'b1;
        expect_st("t5_reset", 0, 1'b0, tk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frames(2);
        btn_start = 1'b0;
        frames(1);

`ifdef GAME_PAUSE_EN
        // Pause round trip; collision ignored while paused.
        press_start();
        expect_play("t6", tk + 1);
        frames(3);
        press_pause();
        expect_st("t6_pause", 4, 1'b0, tk + 1);
        frames(1);
        collision = 1'b1;
        frames(3);
        collision = 1'b0;
        press_pause();
        expect_st("t6_resume", 1, 1'b0, tk + 1);
        frames(2);
`endif

        for (int i = 0; i < 50 && sb.size() != 0; i++)
            @(negedge clk);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            nchk++;
            $display("FAIL %s got=none want=%b@%0d",
                     e.name, e.v, e.t);
        end
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
